// File: rtl/pipe_pkg.sv
// Shared pipeline types: EX/MEM FSM states and control-bit bundle (also used by MEM/WB).
package pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} mem_state_t;

  typedef struct packed {
    logic dmrd;
    logic dmwr;
    logic rfwr;
    logic wd_src;
    logic valid;
  } exmem_ctrl_t;
endpackage

// File: rtl/exmem_timeout_ctr.sv
// Load-clear cycle counter; tc flags the last cycle before LIMIT is reached (LIMIT=0 never flags).
module exmem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign tc = (LIMIT != 0) && (cnt == TC_VAL);
endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with req/ack data-memory sequencer and ack timeout.
// Optional: define EXMEM_ALIGN_CHK_EN to reject misaligned memory ops as bubbles with mem_err.
module exmem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rt_val,
  input  logic [REG_AW-1:0] ex_a3,
  input  logic              ex_dmrd,
  input  logic              ex_dmwr,
  input  logic              ex_rfwr,
  input  logic              ex_wd_src,
  input  logic              ex_valid,
  input  logic              ex_flush,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              mem_stall,
  output logic              mem_valid,
  output logic              mem_rfwr,
  output logic [REG_AW-1:0] mem_a3,
  output logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_err
);
  mem_state_t        state;
  exmem_ctrl_t       ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_q, rt_q, ld_q;
  logic [REG_AW-1:0] a3_q;
  logic              err_q;
  logic              ex_live, ex_mem, misalign, enter, tc;

  assign ex_live = ex_valid & ~ex_flush;
  assign ex_mem  = ex_dmrd | ex_dmwr;
`ifdef EXMEM_ALIGN_CHK_EN
  assign misalign = ex_mem & (ex_alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign enter = (state == IDLE) & ex_live & ex_mem & ~misalign;

  // Bubbles carry no side effects: all enables forced low.
  always_comb begin
    ctrl_d        = '0;
    ctrl_d.wd_src = ex_wd_src;
    if (ex_live && !misalign) begin
      ctrl_d.valid = 1'b1;
      ctrl_d.dmrd  = ex_dmrd;
      ctrl_d.dmwr  = ex_dmwr;
      ctrl_d.rfwr  = ex_rfwr;
    end
  end

  exmem_timeout_ctr #(.LIMIT(ACK_TIMEOUT)) u_to (
    .clk (clk),
    .rst (rst),
    .clr (enter),
    .inc ((state == ACCESS) & ~dm_ack),
    .tc  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ctrl_q <= '0;
      alu_q  <= '0;
      rt_q   <= '0;
      ld_q   <= '0;
      a3_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          alu_q  <= ex_alu_result;
          rt_q   <= ex_rt_val;
          a3_q   <= ex_a3;
          ctrl_q <= ctrl_d;
          if (enter)                state <= ACCESS;
          if (ex_live && misalign)  err_q <= 1'b1;
        end
        ACCESS: begin
          // Ack beats a coincident timeout.
          if (dm_ack) begin
            state <= IDLE;
            if (ctrl_q.dmrd && !ctrl_q.dmwr) ld_q <= dm_rdata;
          end else if (tc) begin
            state        <= IDLE;
            err_q        <= 1'b1;
            ctrl_q.valid <= 1'b0;
            ctrl_q.rfwr  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dm_req      = (state == ACCESS);
  assign mem_stall   = (state == ACCESS);
  assign dm_we       = ctrl_q.dmwr;
  assign dm_addr     = alu_q;
  assign dm_wdata    = rt_q;
  assign mem_valid   = (state == IDLE) & ctrl_q.valid;
  assign mem_rfwr    = mem_valid & ctrl_q.rfwr;
  assign mem_a3      = a3_q;
  assign mem_wb_data = ctrl_q.wd_src ? ld_q : alu_q;
  assign mem_err     = err_q;
endmodule

// File: tb/tb_exmem_stage.sv
// Scoreboard bench for exmem_stage: randomized instruction stream, memory responder, WB monitor.
module tb_exmem_stage;
  localparam int T = 4;

  logic        clk, rst;
  logic [31:0] ex_alu_result, ex_rt_val;
  logic [4:0]  ex_a3;
  logic        ex_dmrd, ex_dmwr, ex_rfwr, ex_wd_src, ex_valid, ex_flush;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_stall, mem_valid, mem_rfwr, mem_err;
  logic [4:0]  mem_a3;
  logic [31:0] mem_wb_data;

  exmem_stage #(.DATA_W(32), .REG_AW(5), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ex_alu_result(ex_alu_result), .ex_rt_val(ex_rt_val), .ex_a3(ex_a3),
    .ex_dmrd(ex_dmrd), .ex_dmwr(ex_dmwr), .ex_rfwr(ex_rfwr), .ex_wd_src(ex_wd_src),
    .ex_valid(ex_valid), .ex_flush(ex_flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .mem_valid(mem_valid), .mem_rfwr(mem_rfwr),
    .mem_a3(mem_a3), .mem_wb_data(mem_wb_data), .mem_err(mem_err)
  );

  typedef struct {
    logic        err;
    logic        rfwr;
    logic [4:0]  a3;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          d;
    logic [31:0] rdata;
    int          cycles;
  } resp_t;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks in the d-th request cycle, checks request fields and stall length.
  resp_t cur;
  int    rcnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      rcnt   = 0;
      dm_ack = 1'b1;
    end else begin
      chk("stall_eq_req", mem_stall, dm_req);
      if (dm_req) begin
        if (rcnt == 0) begin
          if (resp_q.size() == 0) begin
            fail_now("unexpected_dm_req");
            cur = '{addr: dm_addr, we: dm_we, wdata: dm_wdata, d: 1, rdata: 0, cycles: 1};
          end else begin
            cur = resp_q.pop_front();
            chk("dm_addr", dm_addr, cur.addr);
            chk("dm_we", dm_we, cur.we);
            if (cur.we) chk("dm_wdata", dm_wdata, cur.wdata);
          end
        end
        rcnt++;
        dm_ack   = (rcnt == cur.d);
        dm_rdata = (rcnt == cur.d) ? cur.rdata : $urandom;
      end else begin
        if (rcnt != 0) chk("stall_len", rcnt, cur.cycles);
        rcnt     = 0;
        dm_ack   = ($urandom_range(0, 3) == 0);
        dm_rdata = $urandom;
      end
    end
  end

  // WB / error monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_rfwr && !mem_valid) fail_now("rfwr_without_valid");
      if (mem_valid || mem_err) begin
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("mem_err", mem_err, e.err);
          chk("mem_valid", mem_valid, !e.err);
          if (!e.err) begin
            chk("mem_rfwr", mem_rfwr, e.rfwr);
            chk("mem_a3", mem_a3, e.a3);
            chk("mem_wb_data", mem_wb_data, e.data);
          end
        end
      end
    end
  end

  // Issue one instruction and record what the stage must produce for it.
  task automatic issue(input logic v, input logic fl, input logic rd, input logic wr,
                       input logic rf, input logic wds, input logic [4:0] a3,
                       input logic [31:0] alu, input logic [31:0] rt,
                       input int d, input logic [31:0] rdata);
    int   guard;
    logic live, memop, pure_ld;
    guard = 0;
    @(negedge clk);
    while (mem_stall) begin
      guard++;
      if (guard > 50) begin
        fail_now("stall_stuck");
        break;
      end
      @(negedge clk);
    end
    ex_valid = v; ex_flush = fl; ex_dmrd = rd; ex_dmwr = wr; ex_rfwr = rf;
    ex_wd_src = wds; ex_a3 = a3; ex_alu_result = alu; ex_rt_val = rt;
    live    = v && !fl;
    memop   = rd || wr;
    pure_ld = rd && !wr;
    if (live) begin
`ifdef EXMEM_ALIGN_CHK_EN
      if (memop && alu[1:0] != 2'b00) begin
        exp_q.push_back('{err: 1'b1, rfwr: 1'b0, a3: 5'd0, data: 32'd0});
      end else
`endif
      if (memop) begin
        resp_q.push_back('{addr: alu, we: wr, wdata: rt, d: d, rdata: rdata,
                           cycles: (d <= T) ? d : T});
        if (d <= T)
          exp_q.push_back('{err: 1'b0, rfwr: rf, a3: a3,
                            data: (pure_ld && wds) ? rdata : alu});
        else
          exp_q.push_back('{err: 1'b1, rfwr: 1'b0, a3: 5'd0, data: 32'd0});
      end else begin
        exp_q.push_back('{err: 1'b0, rfwr: rf, a3: a3, data: alu});
      end
    end
    @(posedge clk);
    #1 ex_valid = 1'b0; ex_flush = 1'b0;
  endtask

  task automatic drain(input string nm);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || resp_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk(nm, exp_q.size() + resp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    ex_valid = 0; ex_flush = 0; ex_dmrd = 0; ex_dmwr = 0; ex_rfwr = 0; ex_wd_src = 0;
    ex_a3 = '0; ex_alu_result = '0; ex_rt_val = '0;
    dm_ack = 0; dm_rdata = '0;
    #1;
    chk("rst_dm_req", dm_req, 0);
    chk("rst_mem_stall", mem_stall, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_rfwr", mem_rfwr, 0);
    chk("rst_mem_err", mem_err, 0);
    #21 rst = 1'b1;

    // Directed: ALU op, slow load, fast store, flushed load, timeout, ack on timeout edge.
    issue(1, 0, 0, 0, 1, 0, 5'd5, 32'h0000_0010, 32'h0, 0, 32'h0);
    issue(1, 0, 1, 0, 1, 1, 5'd7, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    issue(1, 0, 0, 1, 0, 0, 5'd0, 32'h0000_0204, 32'h1234, 1, 32'h0);
    issue(1, 1, 1, 0, 1, 1, 5'd9, 32'h0000_0300, 32'h0, 1, 32'h5555_AAAA);
    issue(1, 0, 1, 0, 1, 1, 5'd3, 32'h0000_0400, 32'h0, 99, 32'h0);
    issue(1, 0, 0, 0, 1, 0, 5'd6, 32'h0000_0abc, 32'h0, 0, 32'h0);
    issue(1, 0, 1, 0, 1, 1, 5'd8, 32'h0000_0500, 32'h0, T, 32'hCAFE_F00D);
    issue(1, 0, 1, 1, 1, 0, 5'd2, 32'h0000_0600, 32'h77, 2, 32'h0BAD_0BAD);

    // Randomized stream.
    for (int i = 0; i < 150; i++) begin
      int          kind;
      logic        rd, wr, wds;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      rd   = (kind == 1) || (kind == 3);
      wr   = (kind == 2) || (kind == 3);
      wds  = (kind == 1) ? logic'($urandom_range(0, 1)) : 1'b0;
      a    = $urandom;
      issue(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), rd, wr,
            logic'($urandom_range(0, 1)), wds, 5'($urandom), a, $urandom,
            $urandom_range(1, T + 2), $urandom);
    end
    drain("drain_random");

    // Reset in the middle of an access.
    issue(1, 0, 1, 0, 1, 1, 5'd4, 32'h0000_0700, 32'h0, 99, 32'h0);
    @(negedge clk);
    #1 chk("req_before_rst", dm_req, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_dm_req", dm_req, 0);
    chk("rst_async_stall", mem_stall, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    resp_q.delete();
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_dm_req", dm_req, 0);
      chk("post_rst_valid", mem_valid, 0);
      chk("post_rst_err", mem_err, 0);
    end
    issue(1, 0, 0, 0, 1, 0, 5'd11, 32'h0000_0042, 32'h0, 0, 32'h0);
    issue(1, 0, 1, 0, 1, 1, 5'd12, 32'h0000_0800, 32'h0, 2, 32'h1357_9BDF);
    drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
